// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: synchronise, debounce and edge-detect the direction keys, then queue legal turns for the core's step tick.
// Define TURN_QUEUE_EN for a 2-entry turn FIFO; otherwise a single latest-wins holding register is used.
module snake_dir_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter logic [1:0] INIT_DIR        = 2'd0
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic [3:0] key_n,
  input  logic       step,
  input  logic       game_active,
  output logic [1:0] dir,
  output logic       turn_pending,
  output logic [3:0] press,
  output logic [7:0] drop_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [3:0]    r_sync1, r_sync2, r_stable, w_flip;
  logic [CW-1:0] r_cnt [4];
  logic          r_ga_d;
  logic [1:0]    r_q0, r_qn;
  logic [1:0]    w_q0n, w_qnn, w_cand, w_ref;
  logic [2:0]    w_nset, w_drop;
  logic [8:0]    w_sum;
  logic          w_any, w_illegal, w_block, w_pop, w_push, w_live;
  always_comb
    for (int i = 0; i < 4; i++)
      w_flip[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_stable <= '1;
      press    <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1  <= key_n;
      r_sync2  <= r_sync1;
      r_stable <= r_stable ^ w_flip;
      press    <= w_flip & r_stable;
      for (int i = 0; i < 4; i++)
        r_cnt[i] <= (r_sync2[i] == r_stable[i] || w_flip[i]) ? '0 : r_cnt[i] + 1'b1;
    end
  assign w_any  = |press;
  assign w_cand = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
  assign w_nset = 3'(press[0]) + 3'(press[1]) + 3'(press[2]) + 3'(press[3]);
  assign w_live = game_active & r_ga_d;
  assign w_pop  = step & (r_qn != 2'd0);
`ifdef TURN_QUEUE_EN
  logic [1:0] r_q1, w_q1n;
  // New turns are judged against the last queued turn, so UP then LEFT chains legally.
  assign w_ref   = (r_qn == 2'd2) ? r_q1 : (r_qn == 2'd1) ? r_q0 : dir;
  assign w_block = (r_qn == 2'd2);
  always_comb begin
    w_q0n = w_pop ? r_q1 : r_q0;
    w_q1n = r_q1;
    w_qnn = w_pop ? r_qn - 2'd1 : r_qn;
    if (w_push) begin
      if (w_qnn == 2'd0) w_q0n = w_cand;
      else w_q1n = w_cand;
      w_qnn = w_qnn + 2'd1;
    end
  end
`else
  assign w_ref   = dir;
  assign w_block = 1'b0;
  always_comb begin
    w_q0n = w_push ? w_cand : r_q0;
    w_qnn = w_push ? 2'd1 : w_pop ? 2'd0 : r_qn;
  end
`endif
  assign w_illegal = (w_cand == w_ref) || (w_cand == (w_ref ^ 2'd2));
  assign w_push    = w_any & ~w_illegal & ~w_block;
  assign w_drop    = w_any ? w_nset - 3'd1 + 3'(w_illegal | w_block) : 3'd0;
  assign w_sum     = {1'b0, drop_count} + {6'd0, w_drop};
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      r_ga_d       <= 1'b0;
      dir          <= INIT_DIR;
      r_q0         <= '0;
      r_qn         <= '0;
      turn_pending <= 1'b0;
      drop_count   <= '0;
`ifdef TURN_QUEUE_EN
      r_q1         <= '0;
`endif
    end else begin
      r_ga_d <= game_active;
      if (w_live) begin
        r_q0         <= w_q0n;
        r_qn         <= w_qnn;
        turn_pending <= (w_qnn != 2'd0);
        drop_count   <= w_sum[8] ? 8'hFF : w_sum[7:0];
        if (w_pop) dir <= r_q0;
`ifdef TURN_QUEUE_EN
        r_q1         <= w_q1n;
`endif
      end else begin
        r_qn         <= '0;
        turn_pending <= 1'b0;
        if (game_active) dir <= INIT_DIR;
      end
    end
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: per-cycle scoreboard of snake_dir_ctrl against a queue-based reference model.
module tb_snake_dir_ctrl;
  localparam int D = 4;
`ifdef TURN_QUEUE_EN
  localparam int QD = 2;
`else
  localparam int QD = 1;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, step = 1'b0, game_active = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic [1:0] dir;
  logic       turn_pending;
  logic [3:0] press;
  logic [7:0] drop_count;
  typedef struct {logic [1:0] d; logic tp; logic [3:0] p; logic [7:0] dc;} exp_t;
  exp_t       sbq[$];
  int         vectors = 0, miscompares = 0, cyc = 0;
  logic [1:0] mdir;
  int         mq[$];
  int         mdrop;
  logic [3:0] mpress, mstable, kh[$];
  logic       mga_d;

  snake_dir_ctrl #(.DEBOUNCE_CYCLES(D), .INIT_DIR(2'd0)) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .key_n(key_n), .step(step), .game_active(game_active),
    .dir(dir), .turn_pending(turn_pending), .press(press), .drop_count(drop_count));

  always #5 clk = ~clk;

  task automatic mreset();
    mdir = 2'd0; mq.delete(); mdrop = 0; mpress = 4'h0; mstable = 4'hF; kh.delete(); mga_d = 1'b0;
  endtask

  task automatic mstep();
    int cand, refd, nset;
    bit rej, push, all;
    logic [3:0] np;
    logic k;
    push = 0;
    if (!game_active) mq.delete();
    else if (!mga_d) begin mq.delete(); mdir = 2'd0; end
    else begin
      if (mpress != 0) begin
        cand = 0;
        while (!mpress[cand]) cand++;
        nset = $countones(mpress);
        refd = (QD == 2 && mq.size() > 0) ? mq[$] : int'(mdir);
        rej  = (cand == refd) || (cand == (refd ^ 2)) || (mq.size() == 2);
        mdrop = mdrop + nset - 1 + int'(rej);
        if (mdrop > 255) mdrop = 255;
        push = !rej;
      end
      if (step && mq.size() > 0) mdir = 2'(mq.pop_front());
      if (push) begin
        if (QD == 1) mq.delete();
        mq.push_back(cand);
      end
    end
    mga_d = game_active;
    kh.push_back(key_n);
    if (kh.size() > D + 2) void'(kh.pop_front());
    // A key flips once its last D synchronised samples all disagree with the stable level.
    np = 4'h0;
    for (int i = 0; i < 4; i++) begin
      all = 1;
      for (int j = 2; j <= D + 1; j++) begin
        k = (kh.size() > j) ? kh[kh.size() - 1 - j][i] : 1'b1;
        if (k == mstable[i]) all = 0;
      end
      if (all) begin np[i] = mstable[i]; mstable[i] = ~mstable[i]; end
    end
    mpress = np;
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.d = mdir; e.tp = (mq.size() != 0); e.p = mpress; e.dc = 8'(mdrop);
    return e;
  endfunction

  task automatic cycle();
    @(posedge clk);
    cyc++;
    if (!rst_n) mreset(); else mstep();
    sbq.push_back(snap());
    #1;
  endtask

  task automatic cycles(int n);
    repeat (n) cycle();
  endtask

  task automatic tap(logic [3:0] m);
    key_n = key_n & ~m; cycles(8);
    key_n = key_n | m;  cycles(8);
  endtask

  task automatic pulse_step();
    step = 1'b1; cycle(); step = 1'b0; cycles(2);
  endtask

  task automatic mid_reset();
    #1 rst_n = 1'b0;
    #1 mreset();
    sbq.delete();
    sbq.push_back(snap());
    #4 cycles(2);
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic chk(string n, int act, int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", n, cyc, act, want);
    end
  endtask

  always @(negedge clk)
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("dir", int'(dir), int'(e.d));
      chk("turn_pending", int'(turn_pending), int'(e.tp));
      chk("press", int'(press), int'(e.p));
      chk("drop_count", int'(drop_count), int'(e.dc));
    end

  initial begin
    mreset();
    cycles(3);
    rst_n = 1'b1;
    cycles(4);
    // bounce shorter than the debounce window, then a clean DOWN press
    key_n[1] = 1'b0; cycles(3); key_n[1] = 1'b1; cycles(8);
    tap(4'b0010);
    pulse_step();
    tap(4'b1000);
    // restart to RIGHT, then UP followed by LEFT before any step
    game_active = 1'b0; cycles(2); game_active = 1'b1; cycles(2);
    tap(4'b1000);
    tap(4'b0100);
    pulse_step();
    pulse_step();
    // simultaneous presses on keys 0 and 1
    game_active = 1'b0; cycles(2); game_active = 1'b1; cycles(2);
    tap(4'b1000); pulse_step();
    tap(4'b0011); pulse_step();
    // press arriving in the same cycle as step on an empty queue
    key_n[1] = 1'b0; cycles(6);
    step = 1'b1; cycle(); step = 1'b0;
    cycles(2);
    key_n[1] = 1'b1; cycles(8);
    pulse_step();
    // game stops with a turn pending; steps must be ignored
    tap(4'b1000);
    game_active = 1'b0; cycles(2);
    pulse_step(); pulse_step();
    game_active = 1'b1; cycles(3);
    // drive drop_count into saturation
    repeat (90) begin
      key_n = 4'h0; cycles(7);
      key_n = 4'hF; cycles(7);
    end
    tap(4'b0001); tap(4'b0010);
    mid_reset();
    repeat (3000) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) == 0) key_n[i] = ~key_n[i];
      step = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) game_active = ~game_active;
      if ($urandom_range(0, 1499) == 0) mid_reset();
      else cycle();
    end
    step = 1'b0; game_active = 1'b1; key_n = 4'hF;
    cycles(10);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Input stage directly upstream of the snake game core.
- Turns the raw active-low push buttons into a clean, registered movement direction.
- Work done: synchronise, debounce, press-edge detect, reject illegal turns, and buffer turns until the core's next movement step.
- The core samples dir on its step tick; this removes bounce and the 180-degree self-collision from fast double presses.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a key change is accepted (5 ms at 50 MHz); minimum 2.
- INIT_DIR, 2'd0, direction loaded on reset and on each game start.

Ports:
- CLOCK_50  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_n  input  4  raw buttons, active-low, asynchronous; key_n[i] requests direction i.
- step  input  1  one-cycle pulse from core: snake advances this cycle.
- game_active  input  1  high while the core is in its playing state.
- dir  output  2  current direction: 0 RIGHT, 1 DOWN, 2 LEFT, 3 UP.
- turn_pending  output  1  at least one accepted turn is queued.
- press  output  4  one-cycle pulse per debounced press, per key.
- drop_count  output  8  saturating count of rejected or dropped presses.

Behaviour:
- Reset (async, rst_n low): dir=INIT_DIR, turn_pending=0, press=0, drop_count=0, queue empty. Synchroniser and debounce stable state = 1 (released); debounce counters = 0.
- Synchroniser: 2 flops per key.
- Debounce, per key, counter width clog2(DEBOUNCE_CYCLES):
  - When synced != stable, the counter increments.
  - When synced == stable, the counter clears.
  - When the counter == DEBOUNCE_CYCLES-1 and the key still differs, stable flips on the next edge and the counter clears.
- press[i]:
  - Registered; high exactly one cycle, on the edge where stable[i] goes 1->0.
  - First seen high DEBOUNCE_CYCLES+2 edges after key_n[i] falls and stays low.
  - Release generates nothing.
- Arbitration: if several press bits are set in one cycle, the lowest index is the candidate. Each other set bit counts as one drop.
- Reference direction ref:
  - Default build: ref = dir.
  - TURN_QUEUE_EN build: ref = queue tail if the queue is non-empty, else dir.
- Candidate d:
  - Rejected (drop_count+1) if d == ref or d == ref^2 (reverse).
  - Otherwise pushed to the queue.
- All decisions in a cycle use pre-edge register values.
  - step and press in the same cycle: pop uses the old head; push uses ref and fullness evaluated before the pop.
  - Therefore a press arriving with step on an empty queue takes effect at the following step.
- step with queue non-empty: dir <= head on that edge (visible the cycle after step), head popped. step with queue empty: dir unchanged.
- turn_pending = queue non-empty, registered.
- drop_count saturates at 255; multiple drops in one cycle add together, then clamp.
- game_active low: presses are ignored and not counted, step is ignored, queue is flushed, dir is held.
- game_active 0->1 edge (registered detect): dir <= INIT_DIR and queue cleared; presses on that same cycle are ignored.
- Debounce logic runs regardless of game_active.

Optional Feature:
- Macro: TURN_QUEUE_EN.
- Defined: 2-entry FIFO of turns; ref = tail. A press while full is dropped (drop_count+1). Allows quick UP-then-LEFT across two steps.
- Undefined: 1-entry holding register; ref = dir. A legal new press overwrites the pending entry (latest wins, no drop counted).

Test Plan:
- Bench setting: DEBOUNCE_CYCLES=4, game_active=1 unless stated.
- Reset: with dir=3 and drop_count=7, pulse rst_n low mid-cycle -> immediately dir=0, turn_pending=0, drop_count=0, press=0.
- Bounce: key_n[1] low for 3 cycles then high -> no press. Held low -> press=4'b0010 for exactly one cycle, 6 edges after the fall; no pulse on release.
- Turn and reverse: dir=RIGHT. Press DOWN, then pulse step -> dir=1 one cycle after step, turn_pending 1->0. Then press UP (reverse of DOWN) -> rejected, drop_count=1, dir stays 1.
- Queue, dir=RIGHT: press UP, then LEFT before any step.
  - TURN_QUEUE_EN: steps yield dir=3 then dir=2.
  - Default build: LEFT rejected, drop_count=1; first step gives dir=3.
- Simultaneous: dir=UP, press bits 0 and 1 in the same cycle -> RIGHT queued, drop_count+1. Press with step on an empty queue -> dir unchanged at that step, applied at the next.
- Game restart: queue holds a turn, game_active goes low -> turn_pending=0, step ignored. game_active rises -> dir=INIT_DIR next cycle.
